// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates NREQ requesters onto one UART transmitter.
// The FSM moves through IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE. LAUNCH
// strobes tx_data_valid and acks the winner for exactly one cycle. WAIT_BUSY
// waits up to GUARD cycles for the transmitter to raise tx_busy. WAIT_DONE
// waits for tx_busy to fall again. Every output comes straight from a register.
// Optional feature: define UART_TX_ARB_RR_EN for round-robin arbitration.
// Without that macro, arbitration is fixed priority (lowest index wins).
module uart_tx_arb #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 4,
    parameter int GUARD  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DWIDTH-1:0]    req_data,
    output logic [NREQ-1:0]           ack,
    output logic [DWIDTH-1:0]         tx_p_data,
    output logic                      tx_data_valid,
    input  logic                      tx_busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      arb_busy,
    output logic                      guard_err
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(GUARD + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [NREQ-1:0]     r_ack;
    logic                r_valid;
    logic                r_gerr;
    logic [DWIDTH-1:0]   r_pdata;
    logic [OW-1:0]       r_owner;
    logic [CW-1:0]       r_cnt;
    logic                r_arb_busy;

    logic [OW-1:0]       w_sel;
    logic                w_any;
    logic                w_grant;

    assign w_any   = |req;
    assign w_grant = (r_state == S_IDLE) && w_any && !tx_busy;

`ifdef UART_TX_ARB_RR_EN
    logic [OW-1:0] r_ptr;

    // Round-robin pick: the first requester at or after r_ptr, wrapping around.
    always_comb begin
        int j;
        w_sel = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[OW'(j)]) w_sel = OW'(j);
        end
    end

    // Pointer moves to the slot just after the winner on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            if (w_sel == OW'(NREQ - 1)) r_ptr <= '0;
            else                        r_ptr <= w_sel + 1'b1;
        end
    end
`else
    // Fixed priority: the lowest-indexed active request wins.
    always_comb begin
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) w_sel = OW'(k);
        end
    end
`endif

    // Main FSM; every output is registered here, alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_valid    <= 1'b0;
            r_gerr     <= 1'b0;
            r_pdata    <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_arb_busy <= 1'b0;
        end else begin
            r_gerr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_pdata    <= req_data[w_sel*DWIDTH +: DWIDTH];
                        r_owner    <= w_sel;
                        r_ack      <= NREQ'(1) << w_sel;
                        r_valid    <= 1'b1;
                        r_arb_busy <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_ack   <= '0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CW'(GUARD - 1)) begin
                        // The transmitter never took the word: report it and drop the frame.
                        r_cnt      <= '0;
                        r_gerr     <= 1'b1;
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_ack      <= '0;
                    r_valid    <= 1'b0;
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign tx_p_data     = r_pdata;
    assign tx_data_valid = r_valid;
    assign owner         = r_owner;
    assign arb_busy      = r_arb_busy;
    assign guard_err     = r_gerr;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, the data word width, matching the serializer width.
REQ-002 SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-003 SHALL have parameter GUARD, default 4, the maximum cycles to wait for tx_busy to rise after a launch.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, NREQ bits: per-requester send request, held high with data stable until ack.
REQ-007 SHALL have port req_data, input, NREQ*DWIDTH bits: requester i's word at bits [i*DWIDTH +: DWIDTH].
REQ-008 SHALL have port ack, output, NREQ bits: one-hot, one-cycle pulse meaning the word was taken.
REQ-009 SHALL have port tx_p_data, output, DWIDTH bits: the word to the transmitter p_data.
REQ-010 SHALL have port tx_data_valid, output, 1 bit: launch strobe to the transmitter data_valid.
REQ-011 SHALL have port tx_busy, input, 1 bit: transmitter busy.
REQ-012 SHALL have port owner, output, clog2(NREQ) bits: index of the last granted requester.
REQ-013 SHALL have port arb_busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port guard_err, output, 1 bit: one-cycle pulse when a launch is not acknowledged by tx_busy.

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE, when any req bit is 1 and tx_busy=0, SHALL select one requester i per REQ-026/027 and, at that edge:
- latch req_data[i] into tx_p_data;
- set owner=i;
- go to LAUNCH.
REQ-017 IDLE SHALL NOT grant while tx_busy=1, whatever the state of req.
REQ-018 LAUNCH SHALL last exactly one cycle, with tx_data_valid=1 and ack[i]=1 in that cycle only; it then goes to WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on tx_busy=1; a cycle counter counts while tx_busy=0.
REQ-020 WAIT_BUSY, after GUARD cycles with tx_busy=0, SHALL go to IDLE and pulse guard_err for one cycle, with no retry.
REQ-021 WAIT_DONE SHALL go to IDLE on tx_busy=0, so IDLE lasts at least one cycle between frames.
REQ-022 tx_p_data SHALL hold stable from LAUNCH until the next grant.
REQ-023 req and req_data SHALL be ignored outside IDLE; a requester that drops req before being granted is not served.
REQ-024 tx_data_valid SHALL be high only in LAUNCH and ack SHALL be zero outside LAUNCH.
REQ-025 All outputs SHALL be registered, with no combinational path from req or tx_busy to any output.

Configuration
REQ-026 With macro UART_TX_ARB_RR_EN defined, arbitration SHALL be round-robin:
- search starts at the pointer ptr, reset value 0;
- after a grant to i, ptr = (i+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-027 Without UART_TX_ARB_RR_EN, arbitration SHALL be fixed priority, lowest index wins, and no pointer register is built.

Reset
REQ-028 rst=1 SHALL asynchronously force:
- state to IDLE;
- tx_data_valid=0, ack=0, guard_err=0;
- tx_p_data=0, owner=0, ptr=0, guard counter=0.
REQ-029 Reset mid-frame SHALL abandon the frame without an ack, and the first grant after release SHALL follow normal IDLE rules.

Verification
REQ-030 SHALL check the single request: req=0001, req_data[7:0]=0xA5, a transmitter model that raises busy 1 cycle after valid for 10 cycles -> ack=0001 and tx_data_valid for 1 cycle, tx_p_data=0xA5, arb_busy falls 1 cycle after busy falls.
REQ-031 SHALL check round-robin with RR_EN: req=1111 held, words 0x10/0x11/0x12/0x13 -> grant order 0,1,2,3,0 with each ack after the previous frame's busy falls.
REQ-032 SHALL check fixed priority without RR_EN: req=1010 held -> requester 1 is granted repeatedly and requester 3 never is.
REQ-033 SHALL check the guard: a transmitter model that never raises busy, req=0100 -> guard_err pulses GUARD+1 cycles after LAUNCH, then requester 2 is re-granted from IDLE.
REQ-034 SHALL check a foreign busy: tx_busy=1 while req=0001 -> no ack until tx_busy=0, then ack 1 cycle later.
REQ-035 SHALL check reset in WAIT_DONE: assert rst -> all outputs reset immediately, and ptr=0 after release.
